// File: rtl/pipeline_fetch_pkg.sv
// Shared types and constants for the instruction fetch unit.
package pipeline_pkg;

  localparam int PC_W   = 8;
  localparam int INST_W = 16;

  localparam logic [3:0] OP_HALT = 4'hF;

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    HOLD,
    DROP,
    HALTED
  } fetch_state_t;

  // PC arithmetic wraps modulo 256 by construction of the 8-bit result.
  function automatic logic [PC_W-1:0] pc_inc(input logic [PC_W-1:0] pc);
    return pc + PC_W'(2);
  endfunction

endpackage

// File: rtl/pipeline_fetch_if.sv
// Instruction-memory request/acknowledge bundle between fetch unit and memory.
interface pipeline_fetch_if;
  import pipeline_pkg::*;

  logic              imem_req;
  logic [PC_W-1:0]   imem_addr;
  logic              imem_ack;
  logic [INST_W-1:0] imem_rdata;

  modport master (output imem_req, imem_addr, input imem_ack, imem_rdata);
  modport slave  (input imem_req, imem_addr, output imem_ack, imem_rdata);
endinterface

// File: rtl/pipeline_fetch.sv
// Instruction fetch unit: PC, memory handshake, one-entry stall buffer, redirects.
// Optional HALT opcode handling is enabled with `define PIPELINE_FETCH_HALT_EN.
module pipeline_fetch
  import pipeline_pkg::*;
#(
  parameter logic [PC_W-1:0] RESET_PC = 8'h00
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                stall,
  input  logic                br_taken,
  input  logic [PC_W-1:0]     br_target,
  pipeline_fetch_if.master    imem,
  output logic                IF_en,
  output logic [PC_W-1:0]     PC2_out,
  output logic [INST_W-1:0]   inst_out,
  output logic                halted
);

  fetch_state_t      state, state_nxt;
  logic [PC_W-1:0]   pc, pc_nxt;
  logic [PC_W-1:0]   pend_pc, pend_nxt;
  logic [INST_W-1:0] buf_inst;
  logic [PC_W-1:0]   buf_pc2;
  logic              buf_load;

  always_comb begin
    state_nxt      = state;
    pc_nxt         = pc;
    pend_nxt       = pend_pc;
    buf_load       = 1'b0;
    imem.imem_req  = 1'b0;
    imem.imem_addr = '0;
    IF_en          = 1'b0;
    PC2_out        = '0;
    inst_out       = '0;
    halted         = 1'b0;

    case (state)
      IDLE: state_nxt = REQ;

      REQ: begin
        imem.imem_req  = 1'b1;
        imem.imem_addr = pc;
        if (imem.imem_ack) begin
          if (br_taken) begin
            pc_nxt = br_target;
          end else begin
            pc_nxt = pc_inc(pc);
            if (stall) begin
              buf_load  = 1'b1;
              state_nxt = HOLD;
            end else begin
              IF_en    = 1'b1;
              inst_out = imem.imem_rdata;
              PC2_out  = pc_inc(pc);
`ifdef PIPELINE_FETCH_HALT_EN
              if (imem.imem_rdata[INST_W-1 -: 4] == OP_HALT) state_nxt = HALTED;
`endif
            end
          end
        end else if (br_taken) begin
          pend_nxt  = br_target;
          state_nxt = DROP;
        end
      end

      // Buffer contents stay visible while stalled; delivered on the first free cycle.
      HOLD: begin
        inst_out = buf_inst;
        PC2_out  = buf_pc2;
        if (br_taken) begin
          pc_nxt    = br_target;
          state_nxt = REQ;
        end else if (!stall) begin
          IF_en     = 1'b1;
          state_nxt = REQ;
`ifdef PIPELINE_FETCH_HALT_EN
          if (buf_inst[INST_W-1 -: 4] == OP_HALT) state_nxt = HALTED;
`endif
        end
      end

      // Request cannot be withdrawn: keep the old address until the ack, then discard it.
      DROP: begin
        imem.imem_req  = 1'b1;
        imem.imem_addr = pc;
        if (br_taken) pend_nxt = br_target;
        if (imem.imem_ack) begin
          pc_nxt    = br_taken ? br_target : pend_pc;
          state_nxt = REQ;
        end
      end

`ifdef PIPELINE_FETCH_HALT_EN
      HALTED: begin
        halted = 1'b1;
        if (br_taken) begin
          pc_nxt    = br_target;
          state_nxt = REQ;
        end
      end
`endif

      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      pc    <= RESET_PC;
    end else begin
      state <= state_nxt;
      pc    <= pc_nxt;
    end
  end

  always_ff @(posedge clk) begin
    pend_pc <= pend_nxt;
    if (buf_load) begin
      buf_inst <= imem.imem_rdata;
      buf_pc2  <= pc_inc(pc);
    end
  end

endmodule

// File: tb/tb_pipeline_fetch.sv
// Self-checking bench for pipeline_fetch: directed scenarios plus a randomized run
// against a transaction-level model of the expected fetch/delivery stream.
module tb_pipeline_fetch;
  import pipeline_pkg::*;

  logic        clk = 1'b0;
  logic        rst, stall, br_taken;
  logic [7:0]  br_target;
  logic        if_en, w_if_en, halted, w_halted;
  logic [7:0]  pc2, w_pc2;
  logic [15:0] inst, w_inst;
  int          total = 0;
  int          passed = 0;

  pipeline_fetch_if mif();
  pipeline_fetch_if wif();

  pipeline_fetch u_dut (
    .clk(clk), .rst(rst), .stall(stall), .br_taken(br_taken), .br_target(br_target),
    .imem(mif), .IF_en(if_en), .PC2_out(pc2), .inst_out(inst), .halted(halted)
  );

  pipeline_fetch #(.RESET_PC(8'hFE)) u_wrap (
    .clk(clk), .rst(rst), .stall(stall), .br_taken(br_taken), .br_target(br_target),
    .imem(wif), .IF_en(w_if_en), .PC2_out(w_pc2), .inst_out(w_inst), .halted(w_halted)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] memfn(input logic [7:0] a);
    return {4'h5, a, ~a[3:0]};
  endfunction

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; stall = 1'b0; br_taken = 1'b0; br_target = 8'h00;
    mif.imem_ack = 1'b0; mif.imem_rdata = 16'h0;
    wif.imem_ack = 1'b0; wif.imem_rdata = 16'h0;
    repeat (3) next_cycle();
    rst = 1'b0;
    next_cycle();
  endtask

  task automatic test_reset();
    rst = 1'b1; stall = 1'b0; br_taken = 1'b0; br_target = 8'h00;
    mif.imem_ack = 1'b0; mif.imem_rdata = 16'h0;
    wif.imem_ack = 1'b0; wif.imem_rdata = 16'h0;
    for (int i = 0; i < 3; i++) begin
      next_cycle();
      @(negedge clk);
      total++;
      if ({mif.imem_req, mif.imem_addr, if_en, pc2, inst, halted} !== 35'h0)
        $display("FAIL reset_hold%0d got req=%b addr=%h en=%b pc2=%h inst=%h halted=%b exp all 0",
                 i, mif.imem_req, mif.imem_addr, if_en, pc2, inst, halted);
      else passed++;
    end
    next_cycle();
    rst = 1'b0;
    @(negedge clk);
    total++;
    if ({mif.imem_req, if_en} !== 2'b00)
      $display("FAIL reset_rel1 got req=%b en=%b exp 0 0", mif.imem_req, if_en);
    else passed++;
    next_cycle();
    @(negedge clk);
    total++;
    if ({mif.imem_req, mif.imem_addr, if_en} !== {1'b1, 8'h00, 1'b0})
      $display("FAIL reset_first_req got req=%b addr=%h en=%b exp 1 00 0",
               mif.imem_req, mif.imem_addr, if_en);
    else passed++;
  endtask

  task automatic test_stream();
    do_reset();
    mif.imem_ack = 1'b1; mif.imem_rdata = 16'h1234;
    @(negedge clk);
    total++;
    if ({mif.imem_addr, if_en, pc2, inst} !== {8'h00, 1'b1, 8'h02, 16'h1234})
      $display("FAIL stream_0 got addr=%h en=%b pc2=%h inst=%h exp 00 1 02 1234",
               mif.imem_addr, if_en, pc2, inst);
    else passed++;
    next_cycle();
    mif.imem_rdata = 16'h5678;
    @(negedge clk);
    total++;
    if ({mif.imem_req, mif.imem_addr, if_en, pc2, inst} !== {1'b1, 8'h02, 1'b1, 8'h04, 16'h5678})
      $display("FAIL stream_1 got req=%b addr=%h en=%b pc2=%h inst=%h exp 1 02 1 04 5678",
               mif.imem_req, mif.imem_addr, if_en, pc2, inst);
    else passed++;
    next_cycle();
    mif.imem_ack = 1'b0;
    @(negedge clk);
    total++;
    if ({mif.imem_req, mif.imem_addr, if_en, pc2, inst} !== {1'b1, 8'h04, 1'b0, 8'h00, 16'h0})
      $display("FAIL stream_next got req=%b addr=%h en=%b pc2=%h inst=%h exp 1 04 0 00 0000",
               mif.imem_req, mif.imem_addr, if_en, pc2, inst);
    else passed++;
  endtask

  task automatic test_stall();
    do_reset();
    stall = 1'b1; mif.imem_ack = 1'b1; mif.imem_rdata = 16'hABCD;
    @(negedge clk);
    total++;
    if ({mif.imem_req, mif.imem_addr, if_en} !== {1'b1, 8'h00, 1'b0})
      $display("FAIL stall_ack got req=%b addr=%h en=%b exp 1 00 0", mif.imem_req, mif.imem_addr, if_en);
    else passed++;
    next_cycle();
    mif.imem_ack = 1'b0;
    @(negedge clk);
    total++;
    if ({mif.imem_req, if_en, inst, pc2} !== {1'b0, 1'b0, 16'hABCD, 8'h02})
      $display("FAIL stall_hold got req=%b en=%b inst=%h pc2=%h exp 0 0 abcd 02",
               mif.imem_req, if_en, inst, pc2);
    else passed++;
    next_cycle();
    stall = 1'b0;
    @(negedge clk);
    total++;
    if ({mif.imem_req, if_en, inst, pc2} !== {1'b0, 1'b1, 16'hABCD, 8'h02})
      $display("FAIL stall_release got req=%b en=%b inst=%h pc2=%h exp 0 1 abcd 02",
               mif.imem_req, if_en, inst, pc2);
    else passed++;
    next_cycle();
    @(negedge clk);
    total++;
    if ({mif.imem_req, mif.imem_addr, if_en} !== {1'b1, 8'h02, 1'b0})
      $display("FAIL stall_next_req got req=%b addr=%h en=%b exp 1 02 0", mif.imem_req, mif.imem_addr, if_en);
    else passed++;
  endtask

  task automatic test_redirect();
    do_reset();
    br_taken = 1'b1; br_target = 8'h10;
    next_cycle();
    br_taken = 1'b0; mif.imem_ack = 1'b1; mif.imem_rdata = 16'h0BAD;
    next_cycle();
    mif.imem_ack = 1'b0; br_taken = 1'b1; br_target = 8'h40;
    @(negedge clk);
    total++;
    if ({mif.imem_req, mif.imem_addr, if_en} !== {1'b1, 8'h10, 1'b0})
      $display("FAIL redir_start got req=%b addr=%h en=%b exp 1 10 0", mif.imem_req, mif.imem_addr, if_en);
    else passed++;
    next_cycle();
    br_taken = 1'b0;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      total++;
      if ({mif.imem_req, mif.imem_addr, if_en} !== {1'b1, 8'h10, 1'b0})
        $display("FAIL redir_wait%0d got req=%b addr=%h en=%b exp 1 10 0", k, mif.imem_req, mif.imem_addr, if_en);
      else passed++;
      next_cycle();
    end
    mif.imem_ack = 1'b1; mif.imem_rdata = 16'hBEEF;
    @(negedge clk);
    total++;
    if ({mif.imem_req, mif.imem_addr, if_en, inst} !== {1'b1, 8'h10, 1'b0, 16'h0})
      $display("FAIL redir_ack got req=%b addr=%h en=%b inst=%h exp 1 10 0 0000",
               mif.imem_req, mif.imem_addr, if_en, inst);
    else passed++;
    next_cycle();
    mif.imem_ack = 1'b0;
    @(negedge clk);
    total++;
    if ({mif.imem_req, mif.imem_addr, if_en} !== {1'b1, 8'h40, 1'b0})
      $display("FAIL redir_target got req=%b addr=%h en=%b exp 1 40 0", mif.imem_req, mif.imem_addr, if_en);
    else passed++;
  endtask

  task automatic test_wrap();
    do_reset();
    wif.imem_ack = 1'b1; wif.imem_rdata = 16'h1111;
    @(negedge clk);
    total++;
    if ({wif.imem_req, wif.imem_addr, w_if_en, w_pc2, w_inst} !== {1'b1, 8'hFE, 1'b1, 8'h00, 16'h1111})
      $display("FAIL wrap_deliver got req=%b addr=%h en=%b pc2=%h inst=%h exp 1 fe 1 00 1111",
               wif.imem_req, wif.imem_addr, w_if_en, w_pc2, w_inst);
    else passed++;
    next_cycle();
    wif.imem_ack = 1'b0;
    @(negedge clk);
    total++;
    if ({wif.imem_req, wif.imem_addr} !== {1'b1, 8'h00})
      $display("FAIL wrap_next got req=%b addr=%h exp 1 00", wif.imem_req, wif.imem_addr);
    else passed++;
  endtask

  task automatic test_halt();
    do_reset();
    mif.imem_ack = 1'b1; mif.imem_rdata = 16'hF000;
    @(negedge clk);
    total++;
    if ({if_en, inst, pc2} !== {1'b1, 16'hF000, 8'h02})
      $display("FAIL halt_deliver got en=%b inst=%h pc2=%h exp 1 f000 02", if_en, inst, pc2);
    else passed++;
    next_cycle();
    mif.imem_ack = 1'b0;
`ifdef PIPELINE_FETCH_HALT_EN
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      total++;
      if ({mif.imem_req, halted, if_en} !== 3'b010)
        $display("FAIL halt_stopped%0d got req=%b halted=%b en=%b exp 0 1 0", k, mif.imem_req, halted, if_en);
      else passed++;
      next_cycle();
    end
    br_taken = 1'b1; br_target = 8'h20;
    @(negedge clk);
    total++;
    if ({mif.imem_req, halted, if_en} !== 3'b010)
      $display("FAIL halt_br got req=%b halted=%b en=%b exp 0 1 0", mif.imem_req, halted, if_en);
    else passed++;
    next_cycle();
    br_taken = 1'b0;
    @(negedge clk);
    total++;
    if ({mif.imem_req, mif.imem_addr, halted} !== {1'b1, 8'h20, 1'b0})
      $display("FAIL halt_resume got req=%b addr=%h halted=%b exp 1 20 0", mif.imem_req, mif.imem_addr, halted);
    else passed++;
`else
    @(negedge clk);
    total++;
    if ({mif.imem_req, mif.imem_addr, halted} !== {1'b1, 8'h02, 1'b0})
      $display("FAIL halt_ignored got req=%b addr=%h halted=%b exp 1 02 0", mif.imem_req, mif.imem_addr, halted);
    else passed++;
`endif
  endtask

  // Model: program order is a sequence of addresses restarting at each redirect target;
  // every clean ack must fetch the next address, every delivery must be the next one in order.
  task automatic test_random();
    logic [7:0] exp_pc, exp_fetch, prev_addr, t;
    logic       busy, dirty, prev_wait, req, ack;
    int         waitn, delivered;
    exp_pc = 8'h00; exp_fetch = 8'h00; prev_addr = 8'h00;
    busy = 1'b0; dirty = 1'b0; prev_wait = 1'b0; waitn = 0; delivered = 0;
    do_reset();
    for (int cyc = 0; cyc < 3000; cyc++) begin
      req = mif.imem_req;
      if (req && !busy) begin
        busy = 1'b1;
        waitn = int'($urandom_range(0, 2));
      end
      ack = req && (waitn == 0);
      if (req && !ack) waitn--;
      mif.imem_ack = ack;
      mif.imem_rdata = ack ? memfn(mif.imem_addr) : 16'($urandom);
      br_taken = ($urandom_range(0, 9) == 0);
      t = 8'($urandom);
      t[0] = 1'b0;
      br_target = t;
      stall = ($urandom_range(0, 2) == 0);
      @(negedge clk);
      if (prev_wait) begin
        total++;
        if ({req, mif.imem_addr} !== {1'b1, prev_addr})
          $display("FAIL rnd_req_stable cyc=%0d got req=%b addr=%h exp 1 %h", cyc, req, mif.imem_addr, prev_addr);
        else passed++;
      end
      if (br_taken) begin
        total++;
        if (if_en !== 1'b0)
          $display("FAIL rnd_br_no_deliver cyc=%0d got en=%b exp 0", cyc, if_en);
        else passed++;
      end
      if (if_en === 1'b1) begin
        t = exp_pc + 8'd2;
        total++;
        if ({stall, pc2, inst} !== {1'b0, t, memfn(exp_pc)})
          $display("FAIL rnd_deliver cyc=%0d got stall=%b pc2=%h inst=%h exp 0 %h %h",
                   cyc, stall, pc2, inst, t, memfn(exp_pc));
        else passed++;
        exp_pc = t;
        delivered++;
      end else if (req) begin
        total++;
        if ({pc2, inst} !== 24'h0)
          $display("FAIL rnd_idle_zero cyc=%0d got pc2=%h inst=%h exp 00 0000", cyc, pc2, inst);
        else passed++;
      end
      if (ack) begin
        if (!dirty && !br_taken) begin
          total++;
          if (mif.imem_addr !== exp_fetch)
            $display("FAIL rnd_fetch_addr cyc=%0d got addr=%h exp %h", cyc, mif.imem_addr, exp_fetch);
          else passed++;
          exp_fetch = exp_fetch + 8'd2;
        end
        dirty = 1'b0;
        busy = 1'b0;
      end else if (req && br_taken) begin
        dirty = 1'b1;
      end
      if (br_taken) begin
        exp_pc = br_target;
        exp_fetch = br_target;
      end
      prev_wait = req && !ack;
      prev_addr = mif.imem_addr;
      next_cycle();
    end
    mif.imem_ack = 1'b0; br_taken = 1'b0; stall = 1'b0;
    total++;
    if (delivered < 200)
      $display("FAIL rnd_progress got delivered=%0d exp at least 200", delivered);
    else passed++;
  endtask

  initial begin
    test_reset();
    test_stream();
    test_stall();
    test_redirect();
    test_wrap();
    test_halt();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
